// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if
// Purpose : bundles the datapath-side controls and the board-side display
//           pins of the multiplexed 7-segment scan driver.
// Signals :
//   enable       1 = scan runs, 0 = display dark
//   load         1-cycle strobe capturing digits_in/dp_in
//   digits_in    packed 4-bit codes, digit i = [4i+3:4i], digit 0 = LSD
//   dp_in        decimal point per digit
//   lz_suppress  1 = blank leading zeros
//   seg          segments {a..g}, a = MSB (physical polarity)
//   dp           decimal point of the active digit (physical polarity)
//   an           one-hot digit enable (physical polarity)
//   digit_idx    index of the current slot
//   frame_done   1-cycle pulse after each complete scan
// Modports: master = datapath/testbench side, slave = driver side.
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_suppress;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;

  modport master (
    output enable, load, digits_in, dp_in, lz_suppress,
    input  seg, dp, an, digit_idx, frame_done
  );

  modport slave (
    input  enable, load, digits_in, dp_in, lz_suppress,
    output seg, dp, an, digit_idx, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Purpose : time-multiplexed multi-digit 7-segment driver. Captures a packed
//           code word into shadow registers and scans it one digit per slot.
//           Each slot is CLK_DIV cycles: BLANK_CYCLES with all anodes off
//           (anti-ghosting) followed by the lit portion.
// Ports   :
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   io_disp  seg7_scan_driver_if.slave (controls in, display pins out)
// All outputs are registered; polarity is folded in at the output registers.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit HEX_EN         = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave io_disp
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(CLK_DIV);

  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SLOT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [6:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadowDigits;
  logic [NUM_DIGITS-1:0]   r_shadowDp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frameDone;

  state_t                  w_nextState;
  logic [CNT_W-1:0]        w_nextCnt;
  logic [IDX_W-1:0]        w_nextIdx;
  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] w_effDigits;
  logic [NUM_DIGITS-1:0]   w_effDp;
  logic [NUM_DIGITS-1:0]   w_lzBlank;
  logic                    w_zeroRun;
  logic [3:0]              w_code;
  logic                    w_curDp;
  logic                    w_curBlank;
  logic [6:0]              w_nextSeg;
  logic                    w_nextDp;
  logic [NUM_DIGITS-1:0]   w_nextAn;

  // Active-high {a..g} pattern for one code; hex letters only when enabled.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'h0: pattern = 7'b1111110;
      4'h1: pattern = 7'b0110000;
      4'h2: pattern = 7'b1101101;
      4'h3: pattern = 7'b1111001;
      4'h4: pattern = 7'b0110011;
      4'h5: pattern = 7'b1011011;
      4'h6: pattern = 7'b1011111;
      4'h7: pattern = 7'b1110000;
      4'h8: pattern = 7'b1111111;
      4'h9: pattern = 7'b1111011;
      4'hA: pattern = HEX_EN ? 7'b1110111 : 7'b0000000;
      4'hB: pattern = HEX_EN ? 7'b0011111 : 7'b0000000;
      4'hC: pattern = HEX_EN ? 7'b1001110 : 7'b0000000;
      4'hD: pattern = HEX_EN ? 7'b0111101 : 7'b0000000;
      4'hE: pattern = HEX_EN ? 7'b1001111 : 7'b0000000;
      default: pattern = HEX_EN ? 7'b1000111 : 7'b0000000;
    endcase
    return pattern;
  endfunction

  // A load on the same edge as a SHOW entry must already be visible, so the
  // decode path looks through the shadow registers to the incoming data.
  assign w_effDigits = io_disp.load ? io_disp.digits_in : r_shadowDigits;
  assign w_effDp     = io_disp.load ? io_disp.dp_in     : r_shadowDp;

  // Walk from the most significant digit down; a digit is blanked while every
  // digit at or above it is zero. Digit 0 is never part of the walk.
  always_comb begin
    w_zeroRun = io_disp.lz_suppress;
    w_lzBlank = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zeroRun    = w_zeroRun & (w_effDigits[4*k +: 4] == 4'h0);
      w_lzBlank[k] = w_zeroRun;
    end
  end

  // Select the data of the digit owning the current slot.
  always_comb begin
    w_code     = '0;
    w_curDp    = 1'b0;
    w_curBlank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_code     = w_effDigits[4*i +: 4];
        w_curDp    = w_effDp[i];
        w_curBlank = w_lzBlank[i];
      end
    end
  end

  // Next-state logic. The slot counter runs straight through BLANK into SHOW,
  // so a slot is always CLK_DIV cycles regardless of the blank length.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextIdx   = r_idx;
    w_wrap      = 1'b0;
    if (!io_disp.enable) begin
      w_nextState = IDLE;
      w_nextCnt   = '0;
      w_nextIdx   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_nextState = BLANK;
          w_nextCnt   = '0;
          w_nextIdx   = '0;
        end
        BLANK: begin
          w_nextCnt = r_cnt + 1'b1;
          if (r_cnt == BLANK_LAST) w_nextState = SHOW;
        end
        SHOW: begin
          if (r_cnt == SLOT_LAST) begin
            w_nextState = BLANK;
            w_nextCnt   = '0;
            if (r_idx == LAST_IDX) begin
              w_nextIdx = '0;
              w_wrap    = 1'b1;
            end else begin
              w_nextIdx = r_idx + 1'b1;
            end
          end else begin
            w_nextCnt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
          w_nextIdx   = '0;
        end
      endcase
    end
  end

  // Output logic: segments are latched only on SHOW entry and then held, so
  // a mid-slot load cannot disturb the digit currently lit.
  always_comb begin
    w_nextAn  = AN_OFF;
    w_nextSeg = SEG_OFF;
    w_nextDp  = DP_OFF;
    if (w_nextState == SHOW) begin
      if (r_state == SHOW) begin
        w_nextAn  = r_an;
        w_nextSeg = r_seg;
        w_nextDp  = r_dp;
      end else begin
        w_nextAn  = AN_OFF ^ (NUM_DIGITS'(1) << r_idx);
        w_nextSeg = (w_curBlank ? 7'b0000000 : decode(w_code)) ^ SEG_OFF;
        w_nextDp  = w_curDp ^ DP_OFF;
      end
    end
  end

  // State, counters, shadow capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_shadowDigits <= '0;
      r_shadowDp     <= '0;
      r_seg          <= SEG_OFF;
      r_dp           <= DP_OFF;
      r_an           <= AN_OFF;
      r_frameDone    <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_idx       <= w_nextIdx;
      r_seg       <= w_nextSeg;
      r_dp        <= w_nextDp;
      r_an        <= w_nextAn;
      r_frameDone <= w_wrap;
      if (io_disp.load) begin
        r_shadowDigits <= io_disp.digits_in;
        r_shadowDp     <= io_disp.dp_in;
      end
    end
  end

  assign io_disp.seg        = r_seg;
  assign io_disp.dp         = r_dp;
  assign io_disp.an         = r_an;
  assign io_disp.digit_idx  = r_idx;
  assign io_disp.frame_done = r_frameDone;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Two drivers share one stimulus: dut0 decimal-only with active-high
// segments, dut1 hex-enabled with active-low segments. Both use 4 digits,
// 8-cycle slots with 2 blank cycles and active-low anodes.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int WAIT_LIMIT = 200;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dps;
    logic        lz;
    int          idx;
    logic [6:0]  segDec;
    logic [6:0]  segHex;
    logic        dpExp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] digitsIn;
  logic [3:0]  dpIn;
  logic        lzSuppress;

  int checks;
  int errors;
  vec_t vecs[$];

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus0 ();
  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus1 ();

  assign bus0.enable      = enable;
  assign bus0.load        = load;
  assign bus0.digits_in   = digitsIn;
  assign bus0.dp_in       = dpIn;
  assign bus0.lz_suppress = lzSuppress;
  assign bus1.enable      = enable;
  assign bus1.load        = load;
  assign bus1.digits_in   = digitsIn;
  assign bus1.dp_in       = dpIn;
  assign bus1.lz_suppress = lzSuppress;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BLANK),
    .HEX_EN(1'b0), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .io_disp(bus0)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BLANK),
    .HEX_EN(1'b1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .io_disp(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] anExp(input int idx);
    logic [3:0] oneHot;
    oneHot = 4'b0001 << idx;
    return ~oneHot;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Checks both drivers against one logical pattern.
  task automatic checkBoth(input string name, input logic [6:0] segDec,
                           input logic [6:0] segHex, input logic dpLogic);
    logic [6:0] segHexPhys;
    logic       dpPhys;
    segHexPhys = ~segHex;
    dpPhys     = ~dpLogic;
    checkOutput({name, " seg0"}, 32'(bus0.seg), 32'(segDec));
    checkOutput({name, " dp0"},  32'(bus0.dp),  32'(dpLogic));
    checkOutput({name, " seg1"}, 32'(bus1.seg), 32'(segHexPhys));
    checkOutput({name, " dp1"},  32'(bus1.dp),  32'(dpPhys));
  endtask

  task automatic applyStimulus(input logic [15:0] digits, input logic [3:0] dps,
                               input logic lz);
    digitsIn   = digits;
    dpIn       = dps;
    lzSuppress = lz;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  // Returns just after the next SHOW-entry edge of digit idx.
  task automatic waitForShow(input int idx);
    logic [3:0] target;
    int n;
    target = anExp(idx);
    n = 0;
    while (bus0.an == target && n < WAIT_LIMIT) begin tick(); n++; end
    while (bus0.an != target && n < WAIT_LIMIT) begin tick(); n++; end
    if (bus0.an != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitForShow digit %0d: timed out, an=%b expected %b",
               idx, bus0.an, target);
    end
  endtask

  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    load       = 1'b0;
    digitsIn   = '0;
    dpIn       = '0;
    lzSuppress = 1'b0;

    vecs.push_back(vec_t'{16'h1234, 4'b0100, 1'b0, 0, 7'b0110011, 7'b0110011, 1'b0});
    vecs.push_back(vec_t'{16'h1234, 4'b0100, 1'b0, 2, 7'b1101101, 7'b1101101, 1'b1});
    vecs.push_back(vec_t'{16'h1234, 4'b0100, 1'b0, 3, 7'b0110000, 7'b0110000, 1'b0});
    vecs.push_back(vec_t'{16'h0070, 4'b0000, 1'b1, 3, 7'b0000000, 7'b0000000, 1'b0});
    vecs.push_back(vec_t'{16'h0070, 4'b0000, 1'b1, 2, 7'b0000000, 7'b0000000, 1'b0});
    vecs.push_back(vec_t'{16'h0070, 4'b0000, 1'b1, 1, 7'b1110000, 7'b1110000, 1'b0});
    vecs.push_back(vec_t'{16'h0070, 4'b0000, 1'b1, 0, 7'b1111110, 7'b1111110, 1'b0});
    vecs.push_back(vec_t'{16'h0070, 4'b0000, 1'b0, 3, 7'b1111110, 7'b1111110, 1'b0});
    vecs.push_back(vec_t'{16'h0070, 4'b0000, 1'b0, 2, 7'b1111110, 7'b1111110, 1'b0});
    vecs.push_back(vec_t'{16'h000B, 4'b0000, 1'b0, 0, 7'b0000000, 7'b0011111, 1'b0});
    vecs.push_back(vec_t'{16'h00A0, 4'b0000, 1'b0, 1, 7'b0000000, 7'b1110111, 1'b0});
    vecs.push_back(vec_t'{16'h0C00, 4'b1000, 1'b1, 3, 7'b0000000, 7'b0000000, 1'b1});
    vecs.push_back(vec_t'{16'h0C00, 4'b1000, 1'b1, 2, 7'b0000000, 7'b1001110, 1'b0});
    vecs.push_back(vec_t'{16'h0000, 4'b0000, 1'b1, 0, 7'b1111110, 7'b1111110, 1'b0});
    vecs.push_back(vec_t'{16'h0000, 4'b0000, 1'b1, 1, 7'b0000000, 7'b0000000, 1'b0});
    vecs.push_back(vec_t'{16'h0FED, 4'b0001, 1'b0, 0, 7'b0000000, 7'b0111101, 1'b1});
    vecs.push_back(vec_t'{16'h0FED, 4'b0001, 1'b0, 1, 7'b0000000, 7'b1001111, 1'b0});
    vecs.push_back(vec_t'{16'h0FED, 4'b0001, 1'b0, 2, 7'b0000000, 7'b1000111, 1'b0});
    vecs.push_back(vec_t'{16'h5678, 4'b0000, 1'b0, 3, 7'b1011011, 7'b1011011, 1'b0});
    vecs.push_back(vec_t'{16'h5678, 4'b0000, 1'b0, 2, 7'b1011111, 7'b1011111, 1'b0});
    vecs.push_back(vec_t'{16'h5678, 4'b0000, 1'b0, 0, 7'b1111111, 7'b1111111, 1'b0});

    // Reset state
    tick();
    tick();
    checkOutput("reset an0", 32'(bus0.an), 32'(4'b1111));
    checkOutput("reset an1", 32'(bus1.an), 32'(4'b1111));
    checkOutput("reset idx", 32'(bus0.digit_idx), 32'd0);
    checkOutput("reset frame_done", 32'(bus0.frame_done), 32'd0);
    checkBoth("reset", 7'b0000000, 7'b0000000, 1'b0);
    rst_n  = 1'b1;
    tick();
    checkOutput("idle an0", 32'(bus0.an), 32'(4'b1111));
    enable = 1'b1;

    // Table-driven decode, polarity and leading-zero vectors
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].digits, vecs[i].dps, vecs[i].lz);
      waitForShow(vecs[i].idx);
      checkOutput($sformatf("vec%0d an", i), 32'(bus0.an), 32'(anExp(vecs[i].idx)));
      checkOutput($sformatf("vec%0d idx", i), 32'(bus0.digit_idx), 32'(vecs[i].idx));
      checkBoth($sformatf("vec%0d", i), vecs[i].segDec, vecs[i].segHex, vecs[i].dpExp);
    end

    // Slot timing: 6 lit cycles, 2 dark, then the next digit
    applyStimulus(16'h1234, 4'b0100, 1'b0);
    waitForShow(0);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("slot last lit an", 32'(bus0.an), 32'(4'b1110));
    checkOutput("slot last lit seg", 32'(bus0.seg), 32'(7'b0110011));
    tick();
    checkOutput("slot blank1 an", 32'(bus0.an), 32'(4'b1111));
    checkOutput("slot blank1 seg", 32'(bus0.seg), 32'(7'b0000000));
    checkOutput("slot blank1 idx", 32'(bus0.digit_idx), 32'd1);
    tick();
    checkOutput("slot blank2 an", 32'(bus0.an), 32'(4'b1111));
    tick();
    checkOutput("slot next an", 32'(bus0.an), 32'(4'b1101));
    checkOutput("slot next seg", 32'(bus0.seg), 32'(7'b1111001));

    // frame_done: single-cycle pulse every 32 cycles
    n = 0;
    while (bus0.frame_done !== 1'b1 && n < WAIT_LIMIT) begin tick(); n++; end
    checkOutput("frame_done seen", 32'(bus0.frame_done), 32'd1);
    checkOutput("frame_done idx", 32'(bus0.digit_idx), 32'd0);
    checkOutput("frame_done an", 32'(bus0.an), 32'(4'b1111));
    tick();
    checkOutput("frame_done width", 32'(bus0.frame_done), 32'd0);
    n = 1;
    while (bus0.frame_done !== 1'b1 && n < WAIT_LIMIT) begin tick(); n++; end
    checkOutput("frame period", 32'(n), 32'd32);

    // Load during SHOW of digit 1 leaves the lit digit unchanged
    waitForShow(1);
    tick();
    tick();
    applyStimulus(16'h9999, 4'b0000, 1'b0);
    checkOutput("midload an", 32'(bus0.an), 32'(4'b1101));
    checkBoth("midload hold", 7'b1111001, 7'b1111001, 1'b0);
    tick();
    tick();
    checkBoth("midload hold late", 7'b1111001, 7'b1111001, 1'b0);
    waitForShow(2);
    checkBoth("midload next digit", 7'b1111011, 7'b1111011, 1'b0);

    // Load on the SHOW-entry edge is displayed immediately
    waitForShow(0);
    for (int k = 0; k < 7; k++) tick();
    applyStimulus(16'h0050, 4'b0010, 1'b0);
    checkOutput("bypass an", 32'(bus0.an), 32'(4'b1101));
    checkBoth("bypass", 7'b1011011, 7'b1011011, 1'b1);

    // Enable dropped mid-slot 2, then re-enabled
    waitForShow(2);
    tick();
    tick();
    enable = 1'b0;
    tick();
    checkOutput("disable an", 32'(bus0.an), 32'(4'b1111));
    checkOutput("disable idx", 32'(bus0.digit_idx), 32'd0);
    checkOutput("disable frame_done", 32'(bus0.frame_done), 32'd0);
    checkBoth("disable", 7'b0000000, 7'b0000000, 1'b0);
    tick();
    checkOutput("disable hold frame_done", 32'(bus0.frame_done), 32'd0);
    enable = 1'b1;
    tick();
    checkOutput("reenable blank1 an", 32'(bus0.an), 32'(4'b1111));
    tick();
    checkOutput("reenable blank2 an", 32'(bus0.an), 32'(4'b1111));
    tick();
    checkOutput("reenable lit an", 32'(bus0.an), 32'(4'b1110));
    checkBoth("reenable lit", 7'b1111110, 7'b1111110, 1'b0);

    // Asynchronous reset in the middle of SHOW
    waitForShow(1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset an", 32'(bus0.an), 32'(4'b1111));
    checkOutput("async reset idx", 32'(bus0.digit_idx), 32'd0);
    checkBoth("async reset", 7'b0000000, 7'b0000000, 1'b0);
    tick();
    rst_n      = 1'b1;
    lzSuppress = 1'b1;
    waitForShow(0);
    checkBoth("cleared shadow digit0", 7'b1111110, 7'b1111110, 1'b0);
    waitForShow(3);
    checkBoth("cleared shadow digit3", 7'b0000000, 7'b0000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed multi-digit 7-segment display driver. It captures a packed BCD/hex word and scans it onto a shared segment bus, one digit at a time. Features: per-digit anode select, decimal points, optional leading-zero suppression, anti-ghosting blank interval and selectable output polarities. It sits between the datapath and the board display pins and replaces the single-digit combinational decoder.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
CLK_DIV, 1000, clock cycles per digit slot, blank plus show (must exceed BLANK_CYCLES)
BLANK_CYCLES, 2, cycles per slot with all anodes off before segments are shown (>=1)
HEX_EN, 0, 1: codes 10..15 display A,b,C,d,E,F; 0: codes 10..15 display blank
SEG_ACTIVE_LOW, 0, 1: seg/dp pins are active-low
AN_ACTIVE_LOW, 1, 1: an pins are active-low

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  1: scan runs; 0: display dark
load  input  1  1-cycle strobe; captures digits_in/dp_in into shadow registers
digits_in  input  4*NUM_DIGITS  packed codes; digit i = [4i+3:4i]; digit 0 is least significant
dp_in  input  NUM_DIGITS  decimal point per digit
lz_suppress  input  1  1: blank leading zeros
seg  output  7  segments {a,b,c,d,e,f,g}, a = MSB
dp  output  1  decimal point of the active digit
an  output  NUM_DIGITS  one-hot digit enable
digit_idx  output  clog2(NUM_DIGITS), min 1  index of the current slot
frame_done  output  1  1-cycle pulse at the end of each complete scan

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Shadow registers = 0; state = IDLE; slot counter = 0; digit_idx = 0; frame_done = 0.
  - an, seg and dp are driven to their inactive levels. Example: AN_ACTIVE_LOW=1 gives an = all 1s; SEG_ACTIVE_LOW=0 gives seg = 0, dp = 0.
- Output registers: all outputs are registered. Polarity is applied at the output register. The logical values below are active-high.
- Decode, active-high {a..g}:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - With HEX_EN=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - With HEX_EN=0: codes 10..15 give 0000000.
- Shadow capture: load=1 at an edge updates the shadow registers at that edge. This is independent of state. Display data is read only from the shadow registers.
- Leading-zero suppression:
  - Applies when lz_suppress=1. Computed on the shadow registers.
  - Digit k is blanked if every digit j with k <= j <= NUM_DIGITS-1 holds code 0, with k >= 1.
  - Digit 0 is never suppressed.
  - A suppressed digit shows seg = 0000000, but its dp still follows dp_in.
- State machine (IDLE, BLANK, SHOW), slot counter cnt:
  - IDLE: outputs inactive, digit_idx=0. If enable=1: go to BLANK with cnt=0.
  - BLANK: an inactive, seg/dp inactive. cnt increments each cycle. When cnt=BLANK_CYCLES-1: go to SHOW.
  - SHOW:
    - At the entry edge, an asserts the bit digit_idx, and seg/dp are latched from the decode of shadow digit digit_idx.
    - seg/dp hold for the whole slot; a load during SHOW does not change them until the next SHOW entry.
    - When cnt=CLK_DIV-1: go to BLANK with cnt=0. digit_idx increments and wraps from NUM_DIGITS-1 to 0.
  - Slot timing: each slot is exactly CLK_DIV cycles, BLANK_CYCLES dark followed by CLK_DIV-BLANK_CYCLES lit. A frame is NUM_DIGITS*CLK_DIV cycles.
- frame_done: high for the single cycle following the edge where digit_idx wraps from NUM_DIGITS-1 to 0.
- enable=0 in any state: the next edge goes to IDLE. Outputs go inactive, digit_idx=0, cnt=0, and no frame_done pulse. Re-enabling restarts at digit 0, BLANK.
- Simultaneous load and SHOW entry: the newly loaded data is displayed on that same entry edge, because the decode sees the shadow value plus the bypass of load data.
- NUM_DIGITS=1: digit_idx is constant 0, and frame_done pulses every CLK_DIV cycles.

Test Plan:
- Reset with NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, AN_ACTIVE_LOW=1 -> an=4'b1111, seg=0, dp=0, digit_idx=0; rst_n asserted mid-SHOW returns to this state immediately.
- load digits_in=16'h1234, dp_in=4'b0100, enable=1 -> slot 0: 2 dark cycles then 6 cycles of an=4'b1110, seg=0110011 ("4"); slot 2 shows seg=1101101 with dp=1; frame_done pulses every 32 cycles.
- digits_in=16'h0070, lz_suppress=1 -> digits 3 and 2 have seg=0; digit 1 shows 1110000; digit 0 shows 1111110. With lz_suppress=0, digits 3 and 2 show 1111110.
- HEX_EN=0 vs HEX_EN=1 with digit 0 code 4'hB -> seg=0000000 vs seg=0011111; SEG_ACTIVE_LOW=1 inverts these to 1111111 vs 1100000.
- load 16'h9999 during SHOW of digit 1 -> digit 1 keeps its old segments until the slot ends; digit 2 shows 1111011 at its SHOW entry.
- enable dropped during slot 2 -> next cycle an=4'b1111, digit_idx=0, no frame_done; re-enable -> digit 0 lit after 2 blank cycles.
